// File: rtl/width_pack_n.sv
// width_pack_n: packs RATIO narrow IN_W-bit beats into one IN_W*RATIO-bit word.
// Supports lane order selection, valid/ready on both sides, and early emission
// of partial words on last_in or flush_in with a per-lane keep mask.
module width_pack_n #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [IN_W-1:0]         data_in,
  input  logic                    last_in,
  input  logic                    flush_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [IN_W*RATIO-1:0]   data_out,
  output logic [RATIO-1:0]        keep_out,
  output logic                    last_out
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CNT_W = $clog2(RATIO);

  // Beats held in arrival order; the lane mapping is applied only when a word
  // is assembled, so the accumulator needs just RATIO-1 slots.
  logic [IN_W-1:0]  acc [0:RATIO-2];
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cnt_ext;

  logic             out_free;
  logic             accept;
  logic             cnt_full;
  logic             emit_beat;
  logic             emit_flush;
  logic             emit;
  logic [OUT_W-1:0] word;
  logic [RATIO-1:0] word_keep;

  function automatic int unsigned lane_of(input int unsigned k);
    return MSB_FIRST ? (RATIO - 1 - k) : k;
  endfunction

  assign cnt_ext    = 32'(cnt);
  assign out_free   = !valid_out || ready_out;
  assign ready_in   = out_free;
  assign accept     = valid_in && out_free;
  assign cnt_full   = (cnt == CNT_W'(RATIO - 1));
  assign emit_beat  = accept && (cnt_full || last_in || flush_in);
  assign emit_flush = !accept && flush_in && (cnt != '0) && out_free;
  assign emit       = emit_beat || emit_flush;

  // Assemble the outgoing word from held beats plus the beat accepted this cycle.
  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (k < cnt_ext) begin
        word      = word | (OUT_W'(acc[k]) << (lane_of(k) * IN_W));
        word_keep = word_keep | (RATIO'(1) << lane_of(k));
      end
    end
    if (accept) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (k == cnt_ext) begin
          word      = word | (OUT_W'(data_in) << (lane_of(k) * IN_W));
          word_keep = word_keep | (RATIO'(1) << lane_of(k));
        end
      end
    end
  end

  // Accumulator, fill count and output register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) acc[k] <= '0;
      cnt       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (emit) begin
      data_out  <= word;
      keep_out  <= word_keep;
      last_out  <= accept && last_in;
      valid_out <= 1'b1;
      cnt       <= '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) acc[k] <= '0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (accept) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (k == cnt_ext) acc[k] <= data_in;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_width_pack_n.sv
// Testbench for width_pack_n: three configurations (8x2 MSB-first, 8x4
// LSB-first, 8x4 MSB-first) checked against a beat-queue reference model.
module tb_width_pack_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vi [3];
  logic [7:0] di [3];
  logic       li [3];
  logic       fi [3];
  logic       ro [3];
  logic       ri [3];
  logic       vo [3];
  logic       lo [3];
  logic [31:0] dout [3];
  logic [3:0]  kout [3];

  logic [15:0] do_a;
  logic [1:0]  ko_a;
  logic [31:0] do_b, do_c;
  logic [3:0]  ko_b, ko_c;

  width_pack_n #(.IN_W(8), .RATIO(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[0]), .ready_in(ri[0]), .data_in(di[0]),
    .last_in(li[0]), .flush_in(fi[0]), .valid_out(vo[0]), .ready_out(ro[0]),
    .data_out(do_a), .keep_out(ko_a), .last_out(lo[0]));
  width_pack_n #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[1]), .ready_in(ri[1]), .data_in(di[1]),
    .last_in(li[1]), .flush_in(fi[1]), .valid_out(vo[1]), .ready_out(ro[1]),
    .data_out(do_b), .keep_out(ko_b), .last_out(lo[1]));
  width_pack_n #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[2]), .ready_in(ri[2]), .data_in(di[2]),
    .last_in(li[2]), .flush_in(fi[2]), .valid_out(vo[2]), .ready_out(ro[2]),
    .data_out(do_c), .keep_out(ko_c), .last_out(lo[2]));

  assign dout[0] = {16'h0, do_a};
  assign dout[1] = do_b;
  assign dout[2] = do_c;
  assign kout[0] = {2'b0, ko_a};
  assign kout[1] = ko_b;
  assign kout[2] = ko_c;

  int errors = 0;
  int checks = 0;

  // Reference model: beats waiting for a word, plus the expected output register.
  int          cur = 0;
  int          mr = 2;
  bit          mm = 1'b1;
  logic [7:0]  pend [$];
  logic        m_v;
  logic [31:0] m_d;
  logic [3:0]  m_k;
  logic        m_l;
  logic [31:0] got [$];

  task automatic select_dut(input int c);
    cur = c;
    mr  = (c == 0) ? 2 : 4;
    mm  = (c != 1);
  endtask

  task automatic idle_all();
    for (int c = 0; c < 3; c++) begin
      vi[c] = 1'b0; di[c] = 8'h00; li[c] = 1'b0; fi[c] = 1'b0; ro[c] = 1'b1;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_v = 1'b0; m_d = '0; m_k = '0; m_l = 1'b0;
  endtask

  task automatic apply_reset();
    idle_all();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle on the selected DUT: drive, check ready_in, clock, update model, check outputs.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic f,
                      input logic r, output logic acc);
    logic ofree;
    vi[cur] = v; di[cur] = d; li[cur] = l; fi[cur] = f; ro[cur] = r;
    #1;
    ofree = !m_v || r;
    acc   = v && ofree;
    checks++;
    if (ri[cur] !== ofree) begin
      errors++;
      $display("FAIL ready_in dut%0d: got %b want %b", cur, ri[cur], ofree);
    end
    if (vo[cur] === 1'b1 && r) got.push_back(dout[cur]);
    @(posedge clk);
    if (acc) pend.push_back(d);
    if ((acc && (pend.size() == mr || l || f)) || (!acc && f && pend.size() > 0 && ofree)) begin
      m_d = '0; m_k = '0;
      for (int k = 0; k < pend.size(); k++) begin
        int lane;
        lane = mm ? (mr - 1 - k) : k;
        m_d = m_d | (32'(pend[k]) << (8 * lane));
        m_k = m_k | (4'(1) << lane);
      end
      m_l = acc && l;
      m_v = 1'b1;
      pend.delete();
    end else if (m_v && r) begin
      m_v = 1'b0;
    end
    #1;
    checks++;
    if (vo[cur] !== m_v || dout[cur] !== m_d || kout[cur] !== m_k || lo[cur] !== m_l) begin
      errors++;
      $display("FAIL outputs dut%0d: got v=%b d=%h k=%b l=%b want v=%b d=%h k=%b l=%b",
               cur, vo[cur], dout[cur], kout[cur], lo[cur], m_v, m_d, m_k, m_l);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (vo[c] !== 1'b0 || dout[c] !== 32'h0 || kout[c] !== 4'h0 || lo[c] !== 1'b0 || ri[c] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: got v=%b d=%h k=%b l=%b rdy=%b want all zero, rdy=1",
                 c, vo[c], dout[c], kout[c], lo[c], ri[c]);
      end
    end
  endtask

  task automatic test_basic();
    logic a;
    select_dut(0);
    apply_reset();
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, a);
    checks++;
    if (vo[0] !== 1'b1 || dout[0] !== 32'h0000A1B2 || kout[0] !== 4'b0011) begin
      errors++;
      $display("FAIL basic_word: got v=%b d=%h k=%b want v=1 d=0000a1b2 k=0011", vo[0], dout[0], kout[0]);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    checks++;
    if (vo[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got v=%b want 0", vo[0]);
    end
  endtask

  task automatic test_last();
    logic a;
    select_dut(1);
    apply_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, a);
    checks++;
    if (dout[1] !== 32'h00332211 || kout[1] !== 4'b0111 || lo[1] !== 1'b1 || vo[1] !== 1'b1) begin
      errors++;
      $display("FAIL last_word: got v=%b d=%h k=%b l=%b want v=1 d=00332211 k=0111 l=1",
               vo[1], dout[1], kout[1], lo[1]);
    end
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (dout[1] !== 32'h00000044 || kout[1] !== 4'b0001 || lo[1] !== 1'b0) begin
      errors++;
      $display("FAIL last_next_lane0: got d=%h k=%b l=%b want d=00000044 k=0001 l=0",
               dout[1], kout[1], lo[1]);
    end
  endtask

  task automatic test_flush();
    logic a;
    select_dut(2);
    apply_reset();
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (vo[2] !== 1'b1 || dout[2] !== 32'hAABB0000 || kout[2] !== 4'b1100 || lo[2] !== 1'b0) begin
      errors++;
      $display("FAIL flush_word: got v=%b d=%h k=%b l=%b want v=1 d=aabb0000 k=1100 l=0",
               vo[2], dout[2], kout[2], lo[2]);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (vo[2] !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got v=%b want 0", vo[2]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] beats [16];
    logic a, r;
    int b = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    int rdy_low = 0;
    select_dut(0);
    apply_reset();
    got.delete();
    for (int i = 0; i < 16; i++) beats[i] = 8'($urandom);
    for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
      if (!stalled && m_v && cyc > 4) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      r = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (b < 16) step(1'b1, beats[b], 1'b0, 1'b0, r, a);
      else        step(1'b0, 8'h00, 1'b0, 1'b0, r, a);
      if (ri[0] === 1'b0) rdy_low++;
      if (a) b++;
    end
    checks++;
    if (rdy_low != 3) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d want 3", rdy_low);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL bp_word_count: got %0d want 8", got.size());
    end
    for (int w = 0; w < 8 && w < got.size(); w++) begin
      checks++;
      if (got[w] !== {16'h0, beats[2*w], beats[2*w+1]}) begin
        errors++;
        $display("FAIL bp_word%0d: got %h want %h", w, got[w], {16'h0, beats[2*w], beats[2*w+1]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    select_dut(2);
    apply_reset();
    step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'hE3, 1'b0, 1'b0, 1'b1, a);
    apply_reset();
    checks++;
    if (vo[2] !== 1'b0 || dout[2] !== 32'h0 || kout[2] !== 4'h0 || lo[2] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got v=%b d=%h k=%b l=%b want zeros", vo[2], dout[2], kout[2], lo[2]);
    end
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, a);
    checks++;
    if (vo[2] !== 1'b1 || dout[2] !== 32'h01020304 || kout[2] !== 4'b1111) begin
      errors++;
      $display("FAIL midreset_word: got v=%b d=%h k=%b want v=1 d=01020304 k=1111", vo[2], dout[2], kout[2]);
    end
  endtask

  task automatic test_flush_with_beat();
    logic a;
    select_dut(1);
    apply_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 8'h6B, 1'b0, 1'b1, 1'b1, a);
    checks++;
    if (vo[1] !== 1'b1 || dout[1] !== 32'h00006B5A || kout[1] !== 4'b0011 || lo[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_beat_word: got v=%b d=%h k=%b l=%b want v=1 d=00006b5a k=0011 l=0",
               vo[1], dout[1], kout[1], lo[1]);
    end
  endtask

  task automatic test_random();
    logic a;
    for (int c = 0; c < 3; c++) begin
      select_dut(c);
      apply_reset();
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, a);
      end
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    @(posedge clk);
    test_reset();
    test_basic();
    test_last();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_flush_with_beat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/width_pack_n.md
# width_pack_n

Parametrised narrow-to-wide packer: collects `RATIO` consecutive `IN_W`-bit input beats into one `IN_W*RATIO`-bit output word. It supports selectable lane order, valid/ready backpressure on both sides, and early emission of partial words on `last_in` or `flush_in`, with a per-lane keep mask. It sits between narrow byte-stream sources and wide datapath consumers, and is the general replacement for the fixed 8-to-16 stitcher.

## Interface
Parameters:
- `IN_W`, 8, input beat width in bits (>=1)
- `RATIO`, 2, input beats per output word (>=2); `OUT_W = IN_W*RATIO`
- `MSB_FIRST`, 1, 1: first beat lands in the top lane; 0: first beat lands in lane 0

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `valid_in`  in  1  input beat valid
- `ready_in`  out  1  block accepts beat this cycle
- `data_in`  in  IN_W  input beat
- `last_in`  in  1  beat ends a packet; emit word after this beat even if partial
- `flush_in`  in  1  emit any held partial word now
- `valid_out`  out  1  output word valid
- `ready_out`  in  1  consumer accepts word this cycle
- `data_out`  out  OUT_W  packed word
- `keep_out`  out  RATIO  bit i set = lane i (bits `[i*IN_W +: IN_W]`) holds data
- `last_out`  out  1  word closes a packet

## Operation
- Lane i occupies bits `[i*IN_W +: IN_W]`.
- Beat k of a word (k = 0..RATIO-1) goes to lane `RATIO-1-k` if `MSB_FIRST`, otherwise to lane k. With `IN_W=8`, `RATIO=2`, `MSB_FIRST=1`, the output is `{beat0, beat1}`.
- Internal state: an accumulator of RATIO-1 lanes, a fill count `cnt` (0..RATIO-1, `$clog2(RATIO)` bits), and one output register (`data_out`, `keep_out`, `last_out`, `valid_out`).
- `out_free = !valid_out || ready_out`.
- `ready_in = out_free`. This is a combinational path from `ready_out` and must not depend on `valid_in`.
- An input beat is accepted when `valid_in && ready_in`:
  - If `cnt == RATIO-1` or `last_in` is set: load the output register with the accumulator plus this beat. Unfilled lanes are zero. `keep_out` marks the filled lanes. `last_out = last_in`. Set `valid_out`, clear `cnt` and the accumulator.
  - Otherwise: store the beat in its lane and increment `cnt`.
- Flush: when `flush_in && cnt != 0 && out_free` and no beat is accepted, emit the partial word with `last_out = 0`, then clear `cnt`.
  - If a beat is accepted in the same cycle, it is included and the word is emitted (same as `last_in`), with `last_out = last_in`.
  - `flush_in` with `cnt == 0` and no beat accepted has no effect.
  - `flush_in` while `!out_free` is ignored. The source holds it until it takes effect.
- Output handshake: `valid_out` clears on `valid_out && ready_out` unless a new word loads in the same cycle. A new word may load in the same cycle the old word is consumed (back-to-back).
- `data_out` and `keep_out` hold their last values while `valid_out` is low.
- Reset (`rst_n` low at a rising edge): `valid_out = 0`, `data_out = 0`, `keep_out = 0`, `last_out = 0`, `cnt = 0`, accumulator = 0. A partial word in flight is discarded. `ready_in` is 1 one cycle after reset releases.

## Timing
- Latency: completing beat accepted at edge N -> `valid_out` high after edge N, i.e. in cycle N+1.
- Throughput: one input beat per cycle while `ready_out` is held high; one output word every RATIO cycles.
- Stall: `ready_out` low while `valid_out` is high -> `ready_in` low the same cycle. No beat is accepted and the accumulator is frozen.
- Flush: partial word visible one cycle after the edge that samples `flush_in`.

## Test plan
- `IN_W=8`, `RATIO=2`, `MSB_FIRST=1`, `ready_out=1`; beats `0xA1`, `0xB2` in consecutive cycles -> one cycle after the second beat: `data_out=0xA1B2`, `keep_out=2'b11`, `valid_out` for 1 cycle.
- `RATIO=4`, `MSB_FIRST=0`; beats `0x11`, `0x22`, `0x33` with `last_in` on the third -> `data_out=0x00332211`, `keep_out=4'b0111`, `last_out=1`. The next beat `0x44` lands in lane 0.
- `RATIO=4`; 2 beats `0xAA`, `0xBB`, idle, then `flush_in` pulse (`MSB_FIRST=1`) -> `data_out=0xAABB0000`, `keep_out=4'b1100`, `last_out=0`. A later `flush_in` with `cnt=0` produces no output.
- Backpressure: `RATIO=2`, continuous beats, `ready_out` low for 3 cycles while `valid_out=1` -> `ready_in=0` for exactly those cycles, `data_out` stable, no beat lost or duplicated across 8 words.
- Reset mid-word: `RATIO=4`, 3 beats accepted, `rst_n` low for 1 edge -> all outputs 0. The next 4 beats `0x01..0x04` give `data_out=0x01020304` (`MSB_FIRST=1`), `keep_out=4'b1111`.
- Simultaneous `flush_in`, `valid_in` and `last_in=0` at `cnt=1` (`RATIO=4`, `MSB_FIRST=0`, beats `0x5A` then `0x6B`) -> `data_out=0x00006B5A`, `keep_out=4'b0011`, `last_out=0`.
